// File: rtl/opq_sldu_addrgen_arbiter.sv
// opq_sldu_addrgen_arbiter
//
// Shares the single slide/address-generation operand queue between the SLDU
// sequencer and the ADDRGEN sequencer. Commands are granted round-robin with
// a bounded run length. The queue is drained completely before ownership
// moves to the other source, so it never holds beats for both targets.
// A small FIFO of per-command beat counts is matched against consumed beats
// to return command-buffer credits. Protocol errors are sticky.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   sldu_req_*               SLDU command request (valid, len, ready)
//   addrgen_req_*            ADDRGEN command request (valid, len, ready)
//   cmd_valid_o/cmd_ready_i  command handshake towards the operand queue
//   cmd_target_o             0 = SLDU, 1 = ADDRGEN
//   cmd_len_o                beat count of the issued command
//   beat_consumed_i          one beat left the queue
//   beat_target_i            target of that beat
//   owner_o                  0 = none, 1 = SLDU, 2 = ADDRGEN
//   outstanding_cmds_o       commands not yet fully consumed
//   busy_o                   outstanding_cmds_o != 0
//   error_o                  sticky protocol error
//
// state        | meaning
// -------------+--------------------------------------------------------
// IDLE         | no owner, queue empty; round-robin pick of next owner
// OWN_SLDU     | SLDU owns the queue; only SLDU may be granted
// OWN_ADDRGEN  | ADDRGEN owns the queue; only ADDRGEN may be granted
// DRAIN        | switch pending; no grants until every command is consumed

module opq_sldu_addrgen_arbiter #(
   parameter int unsigned CmdBufDepth = 4,
   parameter int unsigned LenWidth    = 16,
   parameter int unsigned MaxRun      = 4
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 sldu_req_valid_i,
   input  logic [LenWidth-1:0]                  sldu_req_len_i,
   output logic                                 sldu_req_ready_o,
   input  logic                                 addrgen_req_valid_i,
   input  logic [LenWidth-1:0]                  addrgen_req_len_i,
   output logic                                 addrgen_req_ready_o,
   output logic                                 cmd_valid_o,
   input  logic                                 cmd_ready_i,
   output logic                                 cmd_target_o,
   output logic [LenWidth-1:0]                  cmd_len_o,
   input  logic                                 beat_consumed_i,
   input  logic                                 beat_target_i,
   output logic [1:0]                           owner_o,
   output logic [$clog2(CmdBufDepth+1)-1:0]     outstanding_cmds_o,
   output logic                                 busy_o,
   output logic                                 error_o
);

   localparam int unsigned CntW = $clog2(CmdBufDepth + 1);
   localparam int unsigned PtrW = (CmdBufDepth > 1) ? $clog2(CmdBufDepth) : 1;
   localparam int unsigned RunW = $clog2(MaxRun + 1);

   localparam logic [1:0] ST_IDLE        = 2'd0;
   localparam logic [1:0] ST_OWN_SLDU    = 2'd1;
   localparam logic [1:0] ST_OWN_ADDRGEN = 2'd2;
   localparam logic [1:0] ST_DRAIN       = 2'd3;

   localparam logic [1:0] OWN_NONE    = 2'd0;
   localparam logic [1:0] OWN_SLDU    = 2'd1;
   localparam logic [1:0] OWN_ADDRGEN = 2'd2;

   localparam logic [CntW-1:0] DEPTH_C   = CntW'(CmdBufDepth);
   localparam logic [PtrW-1:0] PTR_LAST  = PtrW'(CmdBufDepth - 1);
   localparam logic [RunW-1:0] MAX_RUN_C = RunW'(MaxRun);

   logic [1:0]          state_q, state_d;
   logic [1:0]          owner_q, owner_d;
   logic                rr_q, rr_d;       // 0 favours SLDU, 1 favours ADDRGEN
   logic [RunW-1:0]     run_q, run_d;
   logic [CntW-1:0]     count_q;
   logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [LenWidth-1:0] fifo_mem [CmdBufDepth];
   logic [LenWidth-1:0] head_rem_q;
   logic                error_q;

   logic                sldu_zero, addr_zero;
   logic                idle_pick_sldu, idle_pick_addr;
   logic                run_limit;
   logic                sldu_allowed, addr_allowed;
   logic                credit_ok;
   logic                sldu_issue, addr_issue, issue;
   logic                sldu_zack, addr_zack;
   logic                have_cmd;
   logic [LenWidth-1:0] eff_rem;
   logic                pop;
   logic [1:0]          beat_owner;
   logic                err_set;

   // Zero-length FIFO entries are never pushed, so head_rem_q == 0 means the
   // head length has not been loaded yet; read it straight from the FIFO so a
   // beat arriving right after issue is still accounted for.
   assign have_cmd = (count_q != '0);
   assign eff_rem  = (head_rem_q == '0) ? fifo_mem[rd_ptr_q] : head_rem_q;
   assign pop      = beat_consumed_i && have_cmd && (eff_rem == LenWidth'(1));

   assign sldu_zero = (sldu_req_len_i == '0);
   assign addr_zero = (addrgen_req_len_i == '0);

   assign idle_pick_sldu = sldu_req_valid_i && (!addrgen_req_valid_i || !rr_q);
   assign idle_pick_addr = addrgen_req_valid_i && (!sldu_req_valid_i || rr_q);
   assign run_limit      = (run_q == MAX_RUN_C);

   // The owner loses its right to issue once it has used up its run while the
   // other source is waiting; the FSM moves to DRAIN on the same cycle.
   assign sldu_allowed = ((state_q == ST_IDLE) && idle_pick_sldu) ||
                         ((state_q == ST_OWN_SLDU) && !(addrgen_req_valid_i && run_limit));
   assign addr_allowed = ((state_q == ST_IDLE) && idle_pick_addr) ||
                         ((state_q == ST_OWN_ADDRGEN) && !(sldu_req_valid_i && run_limit));

   // A last-beat pop frees a slot in the same cycle, so a full buffer may
   // still accept a command.
   assign credit_ok = (count_q < DEPTH_C) || pop;

   assign sldu_issue = sldu_req_valid_i && sldu_allowed && !sldu_zero && credit_ok && cmd_ready_i;
   assign addr_issue = addrgen_req_valid_i && addr_allowed && !addr_zero && credit_ok && cmd_ready_i;
   assign sldu_zack  = sldu_req_valid_i && sldu_allowed && sldu_zero;
   assign addr_zack  = addrgen_req_valid_i && addr_allowed && addr_zero;
   assign issue      = sldu_issue || addr_issue;

   assign sldu_req_ready_o    = sldu_issue || sldu_zack;
   assign addrgen_req_ready_o = addr_issue || addr_zack;
   assign cmd_valid_o         = issue;
   assign cmd_target_o        = addr_issue;
   assign cmd_len_o           = addr_issue ? addrgen_req_len_i :
                                (sldu_issue ? sldu_req_len_i : '0);

   assign beat_owner = beat_target_i ? OWN_ADDRGEN : OWN_SLDU;
   assign err_set    = beat_consumed_i && (!have_cmd || (owner_q != beat_owner));

   assign owner_o            = owner_q;
   assign outstanding_cmds_o = count_q;
   assign busy_o             = have_cmd;
   assign error_o            = error_q;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      run_d   = run_q;
      case (state_q)
         ST_IDLE: begin
            if (sldu_issue) begin
               state_d = ST_OWN_SLDU;
               owner_d = OWN_SLDU;
               run_d   = RunW'(1);
               rr_d    = 1'b1;
            end else if (addr_issue) begin
               state_d = ST_OWN_ADDRGEN;
               owner_d = OWN_ADDRGEN;
               run_d   = RunW'(1);
               rr_d    = 1'b0;
            end
         end
         ST_OWN_SLDU: begin
            if (!addrgen_req_valid_i) begin
               run_d = '0;
            end else if (sldu_issue) begin
               run_d = run_q + RunW'(1);
            end
            if (addrgen_req_valid_i && (!sldu_req_valid_i || run_limit)) begin
               state_d = ST_DRAIN;
            end else if (!have_cmd && !sldu_req_valid_i && !addrgen_req_valid_i) begin
               state_d = ST_IDLE;
               owner_d = OWN_NONE;
               run_d   = '0;
            end
         end
         ST_OWN_ADDRGEN: begin
            if (!sldu_req_valid_i) begin
               run_d = '0;
            end else if (addr_issue) begin
               run_d = run_q + RunW'(1);
            end
            if (sldu_req_valid_i && (!addrgen_req_valid_i || run_limit)) begin
               state_d = ST_DRAIN;
            end else if (!have_cmd && !sldu_req_valid_i && !addrgen_req_valid_i) begin
               state_d = ST_IDLE;
               owner_d = OWN_NONE;
               run_d   = '0;
            end
         end
         ST_DRAIN: begin
            if (!have_cmd) begin
               state_d = ST_IDLE;
               owner_d = OWN_NONE;
               run_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
            run_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_NONE;
         rr_q    <= 1'b0;
         run_q   <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         run_q   <= run_d;
         if (err_set) begin
            error_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         head_rem_q <= '0;
      end else begin
         if (issue && !pop) begin
            count_q <= count_q + CntW'(1);
         end else if (pop && !issue) begin
            count_q <= count_q - CntW'(1);
         end

         if (issue) begin
            wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PtrW'(1);
         end

         if (beat_consumed_i && have_cmd) begin
            head_rem_q <= pop ? '0 : eff_rem - LenWidth'(1);
         end else if (have_cmd && (head_rem_q == '0)) begin
            head_rem_q <= fifo_mem[rd_ptr_q];
         end
      end
   end

   // Length storage carries no reset: entries are only read behind count_q.
   always_ff @(posedge clk_i) begin
      if (issue) begin
         fifo_mem[wr_ptr_q] <= cmd_len_o;
      end
   end

endmodule

// File: tb/tb_opq_sldu_addrgen_arbiter.sv
// Directed bench for opq_sldu_addrgen_arbiter. Inputs change 1 time unit
// after the rising edge; all outputs are compared at the falling edge.
module tb_opq_sldu_addrgen_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        sldu_req_valid_i;
   logic [15:0] sldu_req_len_i;
   logic        sldu_req_ready_o;
   logic        addrgen_req_valid_i;
   logic [15:0] addrgen_req_len_i;
   logic        addrgen_req_ready_o;
   logic        cmd_valid_o;
   logic        cmd_ready_i;
   logic        cmd_target_o;
   logic [15:0] cmd_len_o;
   logic        beat_consumed_i;
   logic        beat_target_i;
   logic [1:0]  owner_o;
   logic [2:0]  outstanding_cmds_o;
   logic        busy_o;
   logic        error_o;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   opq_sldu_addrgen_arbiter #(
      .CmdBufDepth(4),
      .LenWidth   (16),
      .MaxRun     (4)
   ) dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .sldu_req_valid_i   (sldu_req_valid_i),
      .sldu_req_len_i     (sldu_req_len_i),
      .sldu_req_ready_o   (sldu_req_ready_o),
      .addrgen_req_valid_i(addrgen_req_valid_i),
      .addrgen_req_len_i  (addrgen_req_len_i),
      .addrgen_req_ready_o(addrgen_req_ready_o),
      .cmd_valid_o        (cmd_valid_o),
      .cmd_ready_i        (cmd_ready_i),
      .cmd_target_o       (cmd_target_o),
      .cmd_len_o          (cmd_len_o),
      .beat_consumed_i    (beat_consumed_i),
      .beat_target_i      (beat_target_i),
      .owner_o            (owner_o),
      .outstanding_cmds_o (outstanding_cmds_o),
      .busy_o             (busy_o),
      .error_o            (error_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic mid();
      #4;
   endtask

   task automatic zero_inputs();
      sldu_req_valid_i    = 1'b0;
      sldu_req_len_i      = '0;
      addrgen_req_valid_i = 1'b0;
      addrgen_req_len_i   = '0;
      cmd_ready_i         = 1'b0;
      beat_consumed_i     = 1'b0;
      beat_target_i       = 1'b0;
   endtask

   task automatic do_reset();
      cyc();
      rst_i = 1'b1;
      zero_inputs();
      cyc();
      rst_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1;
      zero_inputs();
      cyc();
      cyc();
      rst_i = 1'b0;
      mid();
      chk("rst_outstanding", 32'(outstanding_cmds_o), 0);
      chk("rst_owner", 32'(owner_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_error", 32'(error_o), 0);
      chk("rst_cmd_valid", 32'(cmd_valid_o), 0);
      chk("rst_sldu_ready", 32'(sldu_req_ready_o), 0);
      chk("rst_addr_ready", 32'(addrgen_req_ready_o), 0);

      // single SLDU command of 3 beats
      cyc();
      sldu_req_valid_i = 1'b1;
      sldu_req_len_i   = 16'd3;
      cmd_ready_i      = 1'b1;
      mid();
      chk("t1_cmd_valid", 32'(cmd_valid_o), 1);
      chk("t1_cmd_target", 32'(cmd_target_o), 0);
      chk("t1_cmd_len", 32'(cmd_len_o), 3);
      chk("t1_sldu_ready", 32'(sldu_req_ready_o), 1);
      chk("t1_addr_ready", 32'(addrgen_req_ready_o), 0);
      cyc();
      sldu_req_valid_i = 1'b0;
      beat_consumed_i  = 1'b1;
      beat_target_i    = 1'b0;
      mid();
      chk("t1_owner", 32'(owner_o), 1);
      chk("t1_out_b1", 32'(outstanding_cmds_o), 1);
      chk("t1_busy_b1", 32'(busy_o), 1);
      cyc();
      mid();
      chk("t1_out_b2", 32'(outstanding_cmds_o), 1);
      cyc();
      mid();
      chk("t1_out_b3", 32'(outstanding_cmds_o), 1);
      chk("t1_busy_b3", 32'(busy_o), 1);
      cyc();
      beat_consumed_i = 1'b0;
      mid();
      chk("t1_out_done", 32'(outstanding_cmds_o), 0);
      chk("t1_busy_done", 32'(busy_o), 0);
      chk("t1_owner_hold", 32'(owner_o), 1);
      cyc();
      mid();
      chk("t1_owner_idle", 32'(owner_o), 0);
      chk("t1_error", 32'(error_o), 0);

      // round-robin, run limit, drain and switch
      do_reset();
      sldu_req_valid_i    = 1'b1;
      sldu_req_len_i      = 16'd1;
      addrgen_req_valid_i = 1'b1;
      addrgen_req_len_i   = 16'd2;
      cmd_ready_i         = 1'b1;
      mid();
      chk("t2_g1_sldu_ready", 32'(sldu_req_ready_o), 1);
      chk("t2_g1_addr_ready", 32'(addrgen_req_ready_o), 0);
      chk("t2_g1_target", 32'(cmd_target_o), 0);
      cyc();
      beat_consumed_i = 1'b1;
      beat_target_i   = 1'b0;
      mid();
      chk("t2_g2_sldu_ready", 32'(sldu_req_ready_o), 1);
      chk("t2_g2_out", 32'(outstanding_cmds_o), 1);
      cyc();
      mid();
      chk("t2_g3_sldu_ready", 32'(sldu_req_ready_o), 1);
      chk("t2_g3_out", 32'(outstanding_cmds_o), 1);
      cyc();
      mid();
      chk("t2_g4_sldu_ready", 32'(sldu_req_ready_o), 1);
      cyc();
      beat_consumed_i = 1'b0;
      mid();
      chk("t2_limit_sldu_ready", 32'(sldu_req_ready_o), 0);
      chk("t2_limit_addr_ready", 32'(addrgen_req_ready_o), 0);
      chk("t2_limit_out", 32'(outstanding_cmds_o), 1);
      cyc();
      beat_consumed_i = 1'b1;
      mid();
      chk("t2_drain_owner", 32'(owner_o), 1);
      chk("t2_drain_addr_ready", 32'(addrgen_req_ready_o), 0);
      cyc();
      beat_consumed_i = 1'b0;
      mid();
      chk("t2_drained_out", 32'(outstanding_cmds_o), 0);
      chk("t2_plus1_addr_ready", 32'(addrgen_req_ready_o), 0);
      chk("t2_plus1_sldu_ready", 32'(sldu_req_ready_o), 0);
      cyc();
      mid();
      chk("t2_plus2_addr_ready", 32'(addrgen_req_ready_o), 1);
      chk("t2_plus2_sldu_ready", 32'(sldu_req_ready_o), 0);
      chk("t2_plus2_target", 32'(cmd_target_o), 1);
      chk("t2_plus2_len", 32'(cmd_len_o), 2);
      chk("t2_plus2_owner", 32'(owner_o), 0);

      // credit exhaustion and same-cycle pop/issue
      do_reset();
      sldu_req_valid_i = 1'b1;
      sldu_req_len_i   = 16'd1;
      cmd_ready_i      = 1'b1;
      for (int i = 0; i < 4; i++) begin
         mid();
         chk($sformatf("t3_grant%0d", i), 32'(sldu_req_ready_o), 1);
         cyc();
      end
      mid();
      chk("t3_full_ready", 32'(sldu_req_ready_o), 0);
      chk("t3_full_cmd_valid", 32'(cmd_valid_o), 0);
      chk("t3_full_out", 32'(outstanding_cmds_o), 4);
      cyc();
      sldu_req_valid_i = 1'b0;
      beat_consumed_i  = 1'b1;
      mid();
      cyc();
      beat_consumed_i  = 1'b0;
      sldu_req_valid_i = 1'b1;
      mid();
      chk("t3_after_pop_out", 32'(outstanding_cmds_o), 3);
      chk("t3_fifth_ready", 32'(sldu_req_ready_o), 1);
      cyc();
      beat_consumed_i = 1'b1;
      mid();
      chk("t3_full_pop_out", 32'(outstanding_cmds_o), 4);
      chk("t3_full_pop_ready", 32'(sldu_req_ready_o), 1);
      cyc();
      beat_consumed_i  = 1'b0;
      sldu_req_valid_i = 1'b0;
      mid();
      chk("t3_same_cycle_out", 32'(outstanding_cmds_o), 4);
      chk("t3_error", 32'(error_o), 0);

      // zero-length ADDRGEN request
      do_reset();
      addrgen_req_valid_i = 1'b1;
      addrgen_req_len_i   = 16'd0;
      cmd_ready_i         = 1'b0;
      mid();
      chk("t4_addr_ready", 32'(addrgen_req_ready_o), 1);
      chk("t4_cmd_valid", 32'(cmd_valid_o), 0);
      chk("t4_sldu_ready", 32'(sldu_req_ready_o), 0);
      cyc();
      addrgen_req_valid_i = 1'b0;
      mid();
      chk("t4_out", 32'(outstanding_cmds_o), 0);
      chk("t4_owner", 32'(owner_o), 0);

      // errors: beat with nothing outstanding, then wrong target
      beat_consumed_i = 1'b1;
      beat_target_i   = 1'b0;
      mid();
      chk("t5_err_before", 32'(error_o), 0);
      cyc();
      beat_consumed_i = 1'b0;
      mid();
      chk("t5_err_empty", 32'(error_o), 1);
      cyc();
      cyc();
      mid();
      chk("t5_err_sticky", 32'(error_o), 1);
      do_reset();
      mid();
      chk("t5_err_cleared", 32'(error_o), 0);
      sldu_req_valid_i = 1'b1;
      sldu_req_len_i   = 16'd2;
      cmd_ready_i      = 1'b1;
      cyc();
      sldu_req_valid_i = 1'b0;
      beat_consumed_i  = 1'b1;
      beat_target_i    = 1'b1;
      mid();
      chk("t5_err_pre_wrong", 32'(error_o), 0);
      chk("t5_owner", 32'(owner_o), 1);
      cyc();
      beat_consumed_i = 1'b0;
      mid();
      chk("t5_err_wrong_target", 32'(error_o), 1);

      // reset during DRAIN with three outstanding commands
      do_reset();
      sldu_req_valid_i = 1'b1;
      sldu_req_len_i   = 16'd5;
      cmd_ready_i      = 1'b1;
      cyc();
      cyc();
      cyc();
      sldu_req_valid_i    = 1'b0;
      addrgen_req_valid_i = 1'b1;
      addrgen_req_len_i   = 16'd1;
      mid();
      chk("t6_addr_blocked", 32'(addrgen_req_ready_o), 0);
      cyc();
      beat_consumed_i = 1'b1;
      beat_target_i   = 1'b1;
      mid();
      chk("t6_drain_out", 32'(outstanding_cmds_o), 3);
      chk("t6_drain_owner", 32'(owner_o), 1);
      cyc();
      beat_consumed_i = 1'b0;
      rst_i           = 1'b1;
      mid();
      chk("t6_err_set", 32'(error_o), 1);
      chk("t6_out_before_rst", 32'(outstanding_cmds_o), 3);
      cyc();
      rst_i               = 1'b0;
      addrgen_req_valid_i = 1'b0;
      sldu_req_valid_i    = 1'b1;
      sldu_req_len_i      = 16'd1;
      mid();
      chk("t6_rst_out", 32'(outstanding_cmds_o), 0);
      chk("t6_rst_owner", 32'(owner_o), 0);
      chk("t6_rst_error", 32'(error_o), 0);
      chk("t6_rst_busy", 32'(busy_o), 0);
      chk("t6_new_sldu_ready", 32'(sldu_req_ready_o), 1);
      chk("t6_new_cmd_valid", 32'(cmd_valid_o), 1);
      cyc();
      sldu_req_valid_i = 1'b0;
      mid();
      chk("t6_new_out", 32'(outstanding_cmds_o), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/opq_sldu_addrgen_arbiter.md
Name: opq_sldu_addrgen_arbiter

Overview:
- Controller that shares the single slide/address-generation operand queue between two command sources: the slide-unit (SLDU) sequencer and the address-generation (ADDRGEN) sequencer.
- Grants commands with round-robin fairness and a bounded run length.
- Guarantees the queue never holds beats for both targets at once: it drains before switching owner.
- Tracks per-command beat counts against consumed beats to manage command-buffer credits, and flags protocol errors.

Parameters:
- CmdBufDepth, 4: command slots in the shared queue; also the credit count.
- LenWidth, 16: width of the per-command beat count (64-bit beats).
- MaxRun, 4: maximum consecutive grants to one owner while the other requester waits.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- sldu_req_valid_i  in  1  SLDU command request
- sldu_req_len_i  in  LenWidth  SLDU command beat count
- sldu_req_ready_o  out  1  SLDU request accepted this cycle
- addrgen_req_valid_i  in  1  ADDRGEN command request
- addrgen_req_len_i  in  LenWidth  ADDRGEN command beat count
- addrgen_req_ready_o  out  1  ADDRGEN request accepted this cycle
- cmd_valid_o  out  1  command to the operand queue
- cmd_ready_i  in  1  operand queue accepts a command
- cmd_target_o  out  1  0 = SLDU, 1 = ADDRGEN
- cmd_len_o  out  LenWidth  beat count of the issued command
- beat_consumed_i  in  1  one beat left the queue (valid & filtered ready)
- beat_target_i  in  1  target of the consumed beat
- owner_o  out  2  0 = none, 1 = SLDU, 2 = ADDRGEN
- outstanding_cmds_o  out  clog2(CmdBufDepth+1)  commands not yet fully consumed
- busy_o  out  1  outstanding_cmds_o != 0
- error_o  out  1  sticky protocol error

Behaviour:
- Reset (rst_i high at a clock edge): FSM=IDLE, RR pointer favours SLDU, run counter 0, length FIFO empty, head remaining 0, error_o 0. All outputs read 0 the cycle after reset. Reset mid-operation discards every outstanding command and credit.
- Grant is combinational and requires all of:
  - requester valid
  - requester allowed by FSM state
  - credits available (outstanding < CmdBufDepth)
  - cmd_ready_i
- On grant: req_ready_o=1 for the granted source only; cmd_valid_o=1; cmd_target_o and cmd_len_o driven from that source. The handshake completes in the same cycle, so latency is 0.
- Zero-length request (len=0): accepted with req_ready_o=1 when the source is allowed. No command is issued, no credit is consumed, and cmd_ready_i is not required.
- Length FIFO (depth CmdBufDepth): a length is pushed on each issued command. The head remaining counter loads the head length when it is empty. Each beat_consumed_i decrements it; reaching 0 pops the head and decrements the outstanding count.
- Simultaneous issue and last-beat pop in one cycle: count unchanged. Issuing is legal with the FIFO full if a pop occurs in the same cycle.
- Errors (error_o set, cleared only by reset):
  - beat_consumed_i with no outstanding command
  - beat_target_i != current owner
- FSM:
  - IDLE: both requesters valid -> grant the RR-favoured one; one valid -> grant it. On grant -> OWN_SLDU or OWN_ADDRGEN, run counter=1, RR pointer favours the other source.
  - OWN_x: only x may be granted. Each grant while the other source is valid increments the run counter; the counter resets to 0 when the other source is not valid.
    - Other source valid and (x not valid, or run counter == MaxRun) -> DRAIN. No grants in DRAIN.
    - Outstanding reaches 0 and no valid requests -> IDLE.
  - DRAIN: no grants. When outstanding == 0 -> IDLE. The RR pointer already favours the waiting source, so the switch costs 2 cycles minimum after the last beat.
- owner_o shows the FSM owner; it keeps the drained owner during DRAIN and reads 0 in IDLE.
- Width rules: counters saturate-free by construction. Outstanding is bounded by CmdBufDepth. Remaining-beat counter is LenWidth bits.

Test Plan:
- Reset, then SLDU len=3, cmd_ready_i=1 -> same-cycle cmd_valid_o=1, target 0, len 3, owner_o=1; 3 consumed beats (target 0) -> outstanding 1->0, busy_o falls on the 3rd beat, FSM returns to IDLE.
- Both requesters valid from IDLE after reset -> SLDU granted first. With ADDRGEN held valid, SLDU grants 4 (MaxRun) times -> DRAIN. After all SLDU beats are consumed, ADDRGEN is granted exactly 2 cycles after the last beat.
- SLDU issues 4 len=1 commands with no consumption -> 5th request sees req_ready_o=0. One beat consumed -> 5th granted the following cycle. Last-beat pop and new issue in the same cycle -> outstanding stays 4.
- Zero-length ADDRGEN request in IDLE -> addrgen_req_ready_o=1, cmd_valid_o=0, outstanding stays 0, FSM stays IDLE.
- beat_consumed_i with target 1 while owner is SLDU, or with outstanding 0 -> error_o=1 next cycle and held until rst_i.
- rst_i asserted with 3 outstanding commands during DRAIN -> next cycle outstanding_cmds_o=0, owner_o=0, error_o=0; a new SLDU request is granted immediately.
